// File: rtl/mac_os_transmitter.sv
// rtl/mac_os_transmitter.sv - MAC-side TS1/TS2/SKP ordered-set and logical-idle symbol generator
// One symbol per clock; a launched set always runs to completion before the next decision.
module mac_os_transmitter #(
  parameter int SKP_INTERVAL = 1180,
  parameter int CTR_W        = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             tx_enable_i,
  input  logic [1:0]       os_sel_i,
  input  logic [7:0]       link_num_i,
  input  logic             link_pad_i,
  input  logic [7:0]       lane_num_i,
  input  logic             lane_pad_i,
  input  logic [7:0]       n_fts_i,
  input  logic [7:0]       data_rate_id_i,
  input  logic [7:0]       train_ctl_i,
  input  logic             ctr_clr_i,
  output logic [7:0]       txdata_o,
  output logic             txdatak_o,
  output logic             en_n_o,
  output logic             os_start_o,
  output logic             os_done_o,
  output logic [1:0]       os_type_o,
  output logic             skp_pending_o,
  output logic [CTR_W-1:0] ts1_sent_ctr_o,
  output logic [CTR_W-1:0] ts2_sent_ctr_o
);

  localparam logic [7:0] SYM_COM  = 8'hBC;
  localparam logic [7:0] SYM_PAD  = 8'hF7;
  localparam logic [7:0] SYM_SKP  = 8'h1C;
  localparam logic [7:0] SYM_TS1  = 8'h4A;
  localparam logic [7:0] SYM_TS2  = 8'h45;
  localparam logic [7:0] SYM_IDLE = 8'h00;
  localparam int               SKP_W    = $clog2(SKP_INTERVAL);
  localparam logic [SKP_W-1:0] SKP_LAST = SKP_W'(SKP_INTERVAL - 1);

  typedef enum logic [1:0] {ST_EIDLE, ST_LIDLE, ST_TS, ST_SKP} state_e;

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             ts2_q, ts2_d;
  logic [7:0]       link_q, link_d, lane_q, lane_d;
  logic             link_pad_q, link_pad_d, lane_pad_q, lane_pad_d;
  logic [7:0]       nfts_q, nfts_d, rate_q, rate_d, tc_q, tc_d;
  logic [SKP_W-1:0] skp_cnt_q, skp_cnt_d;
  logic             skp_pend_q, skp_pend_d;
  logic [CTR_W-1:0] ts1_ctr_q, ts1_ctr_d, ts2_ctr_q, ts2_ctr_d;
  logic [7:0]       txdata_q, txdata_d;
  logic             txdatak_q, txdatak_d, en_n_q, en_n_d;
  logic             os_start_q, os_start_d, os_done_q, os_done_d;
  logic [1:0]       os_type_q, os_type_d;
  logic             set_last, decide, launch_skp;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q + 4'd1;
    ts2_d      = ts2_q;
    link_d     = link_q;
    lane_d     = lane_q;
    link_pad_d = link_pad_q;
    lane_pad_d = lane_pad_q;
    nfts_d     = nfts_q;
    rate_d     = rate_q;
    tc_d       = tc_q;
    skp_cnt_d  = skp_cnt_q;
    skp_pend_d = skp_pend_q;
    ts1_ctr_d  = ts1_ctr_q;
    ts2_ctr_d  = ts2_ctr_q;
    txdata_d   = SYM_IDLE;
    txdatak_d  = 1'b0;
    en_n_d     = 1'b0;
    os_start_d = 1'b0;
    os_done_d  = 1'b0;
    os_type_d  = 2'd0;
    launch_skp = 1'b0;
    set_last   = ((state_q == ST_TS) && (idx_q == 4'd15)) ||
                 ((state_q == ST_SKP) && (idx_q == 4'd3));
    decide     = (state_q == ST_EIDLE) || (state_q == ST_LIDLE) || set_last;

    // Fields are captured only here so mid-set input changes cannot leak into a set.
    if (decide) begin
      idx_d      = 4'd0;
      link_d     = link_num_i;
      lane_d     = lane_num_i;
      link_pad_d = link_pad_i;
      lane_pad_d = lane_pad_i;
      nfts_d     = n_fts_i;
      rate_d     = data_rate_id_i;
      tc_d       = train_ctl_i;
      if (!tx_enable_i) begin
        state_d = ST_EIDLE;
      end else if (skp_pend_q) begin
        state_d    = ST_SKP;
        launch_skp = 1'b1;
      end else if ((os_sel_i == 2'd1) || (os_sel_i == 2'd2)) begin
        state_d = ST_TS;
        ts2_d   = os_sel_i[1];
      end else begin
        state_d = ST_LIDLE;
      end
    end

    case (state_d)
      ST_EIDLE: en_n_d = 1'b1;
      ST_SKP: begin
        txdata_d   = (idx_d == 4'd0) ? SYM_COM : SYM_SKP;
        txdatak_d  = 1'b1;
        os_start_d = (idx_d == 4'd0);
        os_done_d  = (idx_d == 4'd3);
        os_type_d  = 2'd3;
      end
      ST_TS: begin
        os_start_d = (idx_d == 4'd0);
        os_done_d  = (idx_d == 4'd15);
        os_type_d  = ts2_d ? 2'd2 : 2'd1;
        case (idx_d)
          4'd0: begin
            txdata_d  = SYM_COM;
            txdatak_d = 1'b1;
          end
          4'd1: begin
            txdata_d  = link_pad_d ? SYM_PAD : link_d;
            txdatak_d = link_pad_d;
          end
          4'd2: begin
            txdata_d  = lane_pad_d ? SYM_PAD : lane_d;
            txdatak_d = lane_pad_d;
          end
          4'd3:    txdata_d = nfts_d;
          4'd4:    txdata_d = rate_d;
          4'd5:    txdata_d = tc_d;
          default: txdata_d = ts2_d ? SYM_TS2 : SYM_TS1;
        endcase
      end
      default: ;
    endcase

    // Only one SKP can be owed; a later expiry while pending just re-sets the same flag.
    if (state_q == ST_EIDLE) begin
      skp_cnt_d  = '0;
      skp_pend_d = 1'b0;
    end else begin
      if (launch_skp) skp_pend_d = 1'b0;
      if (skp_cnt_q == SKP_LAST) begin
        skp_cnt_d  = '0;
        skp_pend_d = 1'b1;
      end else begin
        skp_cnt_d = skp_cnt_q + SKP_W'(1);
      end
    end

    if (ctr_clr_i) begin
      ts1_ctr_d = '0;
      ts2_ctr_d = '0;
    end else if ((state_d == ST_TS) && (idx_d == 4'd15)) begin
      if (!ts2_d && (ts1_ctr_q != '1)) ts1_ctr_d = ts1_ctr_q + CTR_W'(1);
      if (ts2_d && (ts2_ctr_q != '1))  ts2_ctr_d = ts2_ctr_q + CTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_EIDLE;
      idx_q      <= 4'd0;
      ts2_q      <= 1'b0;
      link_q     <= 8'h00;
      lane_q     <= 8'h00;
      link_pad_q <= 1'b0;
      lane_pad_q <= 1'b0;
      nfts_q     <= 8'h00;
      rate_q     <= 8'h00;
      tc_q       <= 8'h00;
      skp_cnt_q  <= '0;
      skp_pend_q <= 1'b0;
      ts1_ctr_q  <= '0;
      ts2_ctr_q  <= '0;
      txdata_q   <= SYM_IDLE;
      txdatak_q  <= 1'b0;
      en_n_q     <= 1'b1;
      os_start_q <= 1'b0;
      os_done_q  <= 1'b0;
      os_type_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ts2_q      <= ts2_d;
      link_q     <= link_d;
      lane_q     <= lane_d;
      link_pad_q <= link_pad_d;
      lane_pad_q <= lane_pad_d;
      nfts_q     <= nfts_d;
      rate_q     <= rate_d;
      tc_q       <= tc_d;
      skp_cnt_q  <= skp_cnt_d;
      skp_pend_q <= skp_pend_d;
      ts1_ctr_q  <= ts1_ctr_d;
      ts2_ctr_q  <= ts2_ctr_d;
      txdata_q   <= txdata_d;
      txdatak_q  <= txdatak_d;
      en_n_q     <= en_n_d;
      os_start_q <= os_start_d;
      os_done_q  <= os_done_d;
      os_type_q  <= os_type_d;
    end
  end

  assign txdata_o       = txdata_q;
  assign txdatak_o      = txdatak_q;
  assign en_n_o         = en_n_q;
  assign os_start_o     = os_start_q;
  assign os_done_o      = os_done_q;
  assign os_type_o      = os_type_q;
  assign skp_pending_o  = skp_pend_q;
  assign ts1_sent_ctr_o = ts1_ctr_q;
  assign ts2_sent_ctr_o = ts2_ctr_q;

endmodule
